mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the single unified memory port between the instruction-fetch stage (IF) and the data-memory stage (DM) of the pipelined RV32 core. Each request is latched into the port, the port is held until the memory acknowledges it, read data is returned to the owning stage, and each stage is stalled until its own access completes. It sits between the IF/MEM pipeline stages and the memory bus, beside the hazard logic, which consumes its stall outputs.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_WAIT, 4, cycles IF may be denied before it is forced to win (only when fairness is compiled in)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr stable until if_done
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetched word; valid from the if_done cycle until the next IF completion
- if_done  out  1  one-cycle completion pulse
- if_stall  out  1  if_req & ~if_done
- dm_req  in  1  data request; held with dm_* inputs stable until dm_done
- dm_we  in  1  1 = store, 0 = load
- dm_be  in  DW/8  store byte enables
- dm_addr  in  AW  data address
- dm_wdata  in  DW  store data
- dm_rdata  out  DW  load data; updated on load completion only
- dm_done  out  1  one-cycle completion pulse
- dm_stall  out  1  dm_req & ~dm_done
- mem_valid  out  1  port request valid; held until mem_ready
- mem_we  out  1  port write strobe
- mem_be  out  DW/8  port byte enables
- mem_addr  out  AW  port address
- mem_wdata  out  DW  port write data
- mem_ready  in  1  port accept-and-complete; mem_rdata is valid in the same cycle

## Operation
- States: IDLE, BUSY_IF, BUSY_DM.
- IDLE, arbitration:
  - DM has priority over IF.
  - A requester whose done pulse is high in this cycle is ignored, so a stale request is never regranted.
  - On a grant, latch we/be/addr/wdata into the mem_* registers, set mem_valid, and enter BUSY_IF or BUSY_DM.
- IF grants drive mem_we=0, mem_be=all-ones and mem_wdata=0.
- BUSY_x with mem_ready=1:
  - Clear mem_valid.
  - Capture mem_rdata into if_rdata, or into dm_rdata when dm_we=0.
  - Pulse x_done next cycle and return to IDLE.
- BUSY_x with mem_ready=0: hold all mem_* outputs unchanged.
- Only one transaction is outstanding at a time. Requests are never pre-empted.
- Stores complete with dm_done; dm_rdata is unchanged by a store.

## Timing
- All mem_*, *_rdata and *_done outputs are registered. *_stall is combinational.
- Reset values: state IDLE; mem_valid, mem_we, *_done = 0; mem_be, mem_addr, mem_wdata, if_rdata, dm_rdata = 0; age counter = 0.
- Latency: request seen in IDLE in cycle 0 → mem_valid in cycle 1 → mem_ready in cycle 1 → done and data in cycle 2. Minimum is 2 cycles; each extra wait state adds 1.
- In the done cycle the state is IDLE, so the other requester may be granted in that same cycle: back-to-back throughput of 1 access per 2 cycles.
- Simultaneous if_req and dm_req in IDLE → DM wins, and IF stays stalled.
- A reset mid-transaction aborts it: no done pulse, and mem_valid=0 the next cycle. A mem_ready arriving after reset is ignored.
- A mem_ready seen in IDLE is ignored.

## Configuration
- MEM_ARB_FAIR_EN defined:
  - A $clog2(MAX_WAIT+1)-bit age counter increments each cycle in which if_req=1, IF is not busy and IF is not granted; it saturates at MAX_WAIT.
  - When the counter equals MAX_WAIT, the next IDLE arbitration grants IF even if dm_req=1.
  - The counter clears on an IF grant.
- MEM_ARB_FAIR_EN undefined: strict DM priority; the counter logic is absent.

## Structure
- Package mem_arb_pkg:
  - arb_state_t enum {IDLE, BUSY_IF, BUSY_DM}
  - req_id_t enum {REQ_IF, REQ_DM}
  - the all-ones byte-enable constant
- Natural sub-module: mem_arb_age_ctr, the fairness counter, instantiated only under MEM_ARB_FAIR_EN.

## Test plan
- Reset, then idle for 5 cycles → all outputs 0; state IDLE.
- IF read addr 0x100, mem_ready on the first cycle of mem_valid, mem_rdata 0x00000013 → if_done in cycle 2, if_rdata=0x00000013, if_stall high for cycles 0–1.
- Simultaneous DM store (addr 0x2000, wdata 0xDEADBEEF, be 4'b0011) and IF read, 2 wait states each → DM completes first with mem_we=1 and mem_be=4'b0011. IF is granted in the dm_done cycle. dm_rdata is unchanged.
- Load with mem_ready low for 3 cycles → mem_addr and mem_valid stable throughout; dm_done 1 cycle after mem_ready; dm_rdata equals mem_rdata.
- Assert rst while in BUSY_DM, then drive mem_ready=1 after reset → no dm_done; mem_valid=0; no new grant.
- With MEM_ARB_FAIR_EN, MAX_WAIT=4, dm_req held continuously alongside if_req → IF is granted after its age counter reaches 4. Without the macro, IF is never granted while dm_req stays asserted.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
package mem_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arb_state_t;

    // Requester identity
    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_DM = 1'b1
    } req_id_t;

    // Wide enough for any supported data width; users slice [DW/8-1:0]
    localparam int unsigned MAX_BE_W = 64;
    localparam logic [MAX_BE_W-1:0] BE_ALL_ONES = '1;

endpackage

// File: rtl/mem_arb_age_ctr.sv
// Fairness age counter: counts cycles in which IF is kept waiting, saturating at
// MAX_WAIT. Only instantiated when MEM_ARB_FAIR_EN is defined.
module mem_arb_age_ctr #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);
    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] age_q, age_d;

    // Next count: clear wins over increment; increment saturates
    always_comb begin
        age_d = age_q;
        if (clr) begin
            age_d = '0;
        end else if (inc && (age_q != CW'(MAX_WAIT))) begin
            age_d = age_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    assign at_max = (age_q == CW'(MAX_WAIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch (IF) and data
// memory (DM). One access outstanding at a time; DM has priority. Define
// MEM_ARB_FAIR_EN to add an IF age counter that forces an IF grant after
// MAX_WAIT denied cycles.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic [DW-1:0]   if_rdata,
    output logic            if_done,
    output logic            if_stall,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [DW/8-1:0] dm_be,
    input  logic [AW-1:0]   dm_addr,
    input  logic [DW-1:0]   dm_wdata,
    output logic [DW-1:0]   dm_rdata,
    output logic            dm_done,
    output logic            dm_stall,
    output logic            mem_valid,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_ready,
    input  logic [DW-1:0]   mem_rdata
);
    localparam int unsigned BW = DW / 8;

    arb_state_t state_q, state_d;
    logic          mem_valid_q, mem_valid_d;
    logic          mem_we_q, mem_we_d;
    logic [BW-1:0] mem_be_q, mem_be_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          if_done_q, if_done_d;
    logic          dm_done_q, dm_done_d;

    logic    if_elig, dm_elig, force_if, grant_any;
    req_id_t grant_id;

    // A requester in its done cycle still shows its old request; ignore it
    assign if_elig = if_req & ~if_done_q;
    assign dm_elig = dm_req & ~dm_done_q;

`ifdef MEM_ARB_FAIR_EN
    logic if_grant;
    assign if_grant = grant_any & (grant_id == REQ_IF);

    mem_arb_age_ctr #(
        .MAX_WAIT(MAX_WAIT)
    ) u_age_ctr (
        .clk   (clk),
        .rst   (rst),
        .inc   (if_req & (state_q != BUSY_IF) & ~if_grant),
        .clr   (if_grant),
        .at_max(force_if)
    );
`else
    assign force_if = 1'b0;
`endif

    // Arbitration: DM first unless IF has aged out
    always_comb begin
        grant_any = (state_q == IDLE) & (if_elig | dm_elig);
        grant_id  = (dm_elig & ~(force_if & if_elig)) ? REQ_DM : REQ_IF;
    end

    // FSM next state and registered port/response values
    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_any) begin
                    mem_valid_d = 1'b1;
                    if (grant_id == REQ_DM) begin
                        mem_we_d    = dm_we;
                        mem_be_d    = dm_be;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                        state_d     = BUSY_DM;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_be_d    = BE_ALL_ONES[BW-1:0];
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        state_d     = BUSY_IF;
                    end
                end
            end
            BUSY_IF: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    if_rdata_d  = mem_rdata;
                    if_done_d   = 1'b1;
                    state_d     = IDLE;
                end
            end
            BUSY_DM: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    // Stores leave the load-data register untouched
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                    dm_done_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;
    assign if_stall  = if_req & ~if_done_q;
    assign dm_stall  = dm_req & ~dm_done_q;

endmodule
